// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_param
// Description : Parametrised Moore serial pattern detector. Watches a
//               qualified single-bit stream and raises Z when the last N
//               accepted bits equal a runtime-loadable pattern. Matching is
//               overlapping or non-overlapping per instance. Matches are
//               counted in a saturating counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N        : pattern length in bits (1..32)
//   PAT_RST  : pattern value after reset (N bits)
//   OVERLAP  : 1 = overlapping matches, 0 = history discarded after a match
//   CNT_W    : match counter width (>= 1)
// Ports
//   clk        in   1      : clock, all state changes on rising edge
//   rst        in   1      : synchronous active-high reset
//   X          in   1      : serial data bit
//   in_valid   in   1      : X accepted on an edge where this is 1
//   pat_load   in   1      : load pat_in as the new pattern
//   pat_in     in   N      : new pattern, [N-1] oldest bit, [0] newest bit
//   cnt_clr    in   1      : clear the match counter
//   Z          out  1      : registered match flag
//   match_cnt  out  CNT_W  : saturating match count
//   fill       out  FILL_W : number of valid history bits, 0..N
// ============================================================================
module seq_detect_param #(
    parameter int             N       = 3,
    parameter logic [N-1:0]   PAT_RST = 3'b010,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8,
    localparam int            FILL_W  = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              X,
    input  logic              in_valid,
    input  logic              pat_load,
    input  logic [N-1:0]      pat_in,
    input  logic              cnt_clr,
    output logic              Z,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [FILL_W-1:0] fill
);

    localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(N);
    localparam logic [CNT_W-1:0]  c_CNT_MAX   = '1;

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    logic [N-1:0]      pat_q,  pat_d;
    logic [N-1:0]      hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              z_q,    z_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    // ------------------------------------------------------------------
    // Candidate history / fill after accepting the current bit
    // ------------------------------------------------------------------
    logic [N-1:0]      w_hist_n;
    logic [FILL_W-1:0] w_fill_n;
    logic              w_accept;
    logic              w_hit;

    generate
        if (N == 1) begin : g_hist_single
            assign w_hist_n = X;
        end else begin : g_hist_shift
            // Newest bit enters at LSB so the history lines up with pat_q,
            // whose MSB is the oldest bit of the pattern.
            assign w_hist_n = {hist_q[N-2:0], X};
        end
    endgenerate

    // fill saturates at N: once armed, every new bit keeps the window full.
    assign w_fill_n = (fill_q == c_FILL_FULL) ? c_FILL_FULL : fill_q + 1'b1;

    // A load in the same cycle discards the incoming bit.
    assign w_accept = in_valid & ~pat_load;

    // A match needs a full window of bits gathered since the last restart.
    assign w_hit = w_accept && (w_fill_n == c_FILL_FULL) && (w_hist_n == pat_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = z_q;
        cnt_d  = cnt_q;

        if (pat_load) begin
            // History contents are left alone; fill = 0 marks them stale.
            pat_d  = pat_in;
            fill_d = '0;
            z_d    = 1'b0;
        end else if (in_valid) begin
            hist_d = w_hist_n;
            z_d    = w_hit;
            if (w_hit && !OVERLAP) begin
                fill_d = '0;
            end else begin
                fill_d = w_fill_n;
            end
        end

        // The clear acts regardless of pat_load; a simultaneous hit still
        // counts as the first match after the clear.
        if (cnt_clr) begin
            cnt_d = w_hit ? CNT_W'(1) : '0;
        end else if (w_hit && (cnt_q != c_CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q  <= PAT_RST;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
        end
    end

    assign Z         = z_q;
    assign match_cnt = cnt_q;
    assign fill      = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_param
// Description : Self-checking bench for seq_detect_param. Five builds share
//               one stimulus stream: default 010 overlap, non-overlap, 2-bit
//               counter, N=1 and N=32. A queue-based reference model predicts
//               Z / match_cnt / fill per build; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst, X, in_valid, pat_load, cnt_clr;
    logic [31:0] pat_in32;

    logic        z0, z1, z2, z3, z4;
    logic [7:0]  cnt0, cnt1, cnt3, cnt4;
    logic [1:0]  cnt2;
    logic [1:0]  fill0, fill1, fill2;
    logic [0:0]  fill3;
    logic [5:0]  fill4;

    always #5 clk = ~clk;

    seq_detect_param #(.N(3), .PAT_RST(3'b010), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .X(X), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in32[2:0]), .cnt_clr(cnt_clr), .Z(z0), .match_cnt(cnt0), .fill(fill0));
    seq_detect_param #(.N(3), .PAT_RST(3'b010), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .X(X), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in32[2:0]), .cnt_clr(cnt_clr), .Z(z1), .match_cnt(cnt1), .fill(fill1));
    seq_detect_param #(.N(3), .PAT_RST(3'b010), .OVERLAP(1'b1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .X(X), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in32[2:0]), .cnt_clr(cnt_clr), .Z(z2), .match_cnt(cnt2), .fill(fill2));
    seq_detect_param #(.N(1), .PAT_RST(1'b1), .OVERLAP(1'b1), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .X(X), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in32[0:0]), .cnt_clr(cnt_clr), .Z(z3), .match_cnt(cnt3), .fill(fill3));
    seq_detect_param #(.N(32), .PAT_RST(32'hDEADBEEF), .OVERLAP(1'b1), .CNT_W(8)) u4 (
        .clk(clk), .rst(rst), .X(X), .in_valid(in_valid), .pat_load(pat_load),
        .pat_in(pat_in32), .cnt_clr(cnt_clr), .Z(z4), .match_cnt(cnt4), .fill(fill4));

    // ------------------------------------------------------------------
    // Scoreboard bookkeeping
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [NI-1:0]   z;
        logic [NI*8-1:0] cnt;
        logic [NI*6-1:0] fill;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per build, the bits accepted since the last restart
    // (reset, load, or non-overlap match) are kept in a log; a hit is the
    // last N logged bits reading out the pattern, newest bit = pat[0].
    // ------------------------------------------------------------------
    int          M_N  [NI] = '{3, 3, 3, 1, 32};
    bit          M_OV [NI] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    int          M_CW [NI] = '{8, 8, 2, 8, 8};
    logic [31:0] M_PR [NI] = '{32'd2, 32'd2, 32'd2, 32'd1, 32'hDEADBEEF};

    logic [31:0] m_pat [NI];
    int          m_n   [NI];
    bit          m_z   [NI];
    int          m_cnt [NI];
    bit          m_log [NI][64];

    task automatic model_edge(input int k, input bit r, input bit pl, input bit iv,
                              input bit x, input bit clr, input logic [31:0] pin);
        logic [63:0] mask;
        bit          hit;
        int          maxc;
        mask = (64'd1 << M_N[k]) - 64'd1;
        if (r) begin
            m_pat[k] = M_PR[k];
            m_n[k]   = 0;
            m_z[k]   = 1'b0;
            m_cnt[k] = 0;
        end else begin
            hit = 1'b0;
            if (pl) begin
                m_pat[k] = pin & mask[31:0];
                m_n[k]   = 0;
                m_z[k]   = 1'b0;
            end else if (iv) begin
                m_log[k][m_n[k] % 64] = x;
                m_n[k]++;
                hit = (m_n[k] >= M_N[k]);
                for (int j = 0; j < M_N[k]; j++)
                    if (m_log[k][(m_n[k] - 1 - j) % 64] != m_pat[k][j]) hit = 1'b0;
                m_z[k] = hit;
                if (hit && !M_OV[k]) m_n[k] = 0;
            end
            maxc = (1 << M_CW[k]) - 1;
            if (clr) m_cnt[k] = hit ? 1 : 0;
            else if (hit && m_cnt[k] < maxc) m_cnt[k]++;
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs, queue them.
    task automatic step(input bit r, input bit pl, input bit iv, input bit x,
                        input bit clr, input logic [31:0] pin);
        exp_t e;
        int   f;
        rst = r; pat_load = pl; in_valid = iv; X = x; cnt_clr = clr; pat_in32 = pin;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            model_edge(k, r, pl, iv, x, clr, pin);
            f = (m_n[k] < M_N[k]) ? m_n[k] : M_N[k];
            e.z[k]          = m_z[k];
            e.cnt[k*8 +: 8] = m_cnt[k][7:0];
            e.fill[k*6 +: 6] = f[5:0];
        end
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic bit_in(input bit x);
        step(1'b0, 1'b0, 1'b1, x, 1'b0, 32'd0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: outputs are presented every cycle, compare just after edge
    // ------------------------------------------------------------------
    logic [7:0] a_cnt  [NI];
    logic [5:0] a_fill [NI];
    logic [NI-1:0] a_z;
    always_comb begin
        a_z       = {z4, z3, z2, z1, z0};
        a_cnt[0]  = cnt0;  a_cnt[1] = cnt1;  a_cnt[2] = {6'd0, cnt2};
        a_cnt[3]  = cnt3;  a_cnt[4] = cnt4;
        a_fill[0] = {4'd0, fill0}; a_fill[1] = {4'd0, fill1};
        a_fill[2] = {4'd0, fill2}; a_fill[3] = {5'd0, fill3};
        a_fill[4] = fill4;
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("u%0d Z", k),    int'(a_z[k]),    int'(e.z[k]));
                chk($sformatf("u%0d cnt", k),  int'(a_cnt[k]),  int'(e.cnt[k*8 +: 8]));
                chk($sformatf("u%0d fill", k), int'(a_fill[k]), int'(e.fill[k*6 +: 6]));
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    bit          s010101[11] = '{0,1,0,1,0,1,0,1,0,1,0};
    logic [31:0] p32;
    bit          b;

    initial begin
        rst = 1'b1; X = 1'b0; in_valid = 1'b0; pat_load = 1'b0; cnt_clr = 1'b0;
        pat_in32 = 32'd0;

        do_reset();
        do_reset();
        chk("reset Z", int'(z0), 0);
        chk("reset cnt", int'(cnt0), 0);
        chk("reset fill", int'(fill0), 0);

        // Default overlap: 0,1,0,1,0,0
        for (int i = 0; i < 5; i++) begin
            bit_in(s010101[i]);
            chk($sformatf("t1 Z bit%0d", i + 1), int'(z0), (i == 2 || i == 4) ? 1 : 0);
        end
        bit_in(1'b0);
        chk("t1 Z bit6", int'(z0), 0);
        chk("t1 cnt", int'(cnt0), 2);

        // Non-overlap: 0,1,0,1,0,1,0
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bit_in(s010101[i]);
            chk($sformatf("t2 Z bit%0d", i + 1), int'(z1), (i == 2 || i == 6) ? 1 : 0);
        end
        chk("t2 cnt", int'(cnt1), 2);

        // Gaps and load
        do_reset();
        bit_in(1'b0);
        repeat (3) idle();
        chk("t3 fill gap1", int'(fill0), 1);
        bit_in(1'b1);
        repeat (3) idle();
        chk("t3 Z gap2", int'(z0), 0);
        chk("t3 fill gap2", int'(fill0), 2);
        bit_in(1'b0);
        chk("t3 Z match", int'(z0), 1);
        repeat (2) idle();
        chk("t3 Z hold", int'(z0), 1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'd7);
        chk("t3 load fill", int'(fill0), 0);
        chk("t3 load Z", int'(z0), 0);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("t3 Z 2nd one", int'(z0), 0);
        bit_in(1'b1);
        chk("t3 Z 111", int'(z0), 1);

        // Counter saturation on the 2-bit build, then clear on a hit
        do_reset();
        for (int i = 0; i < 11; i++) begin
            bit_in(s010101[i]);
            if (i >= 2 && (i % 2 == 0))
                chk($sformatf("t4 cnt match%0d", i / 2), int'(cnt2),
                    (i / 2 >= 3) ? 3 : i / 2);
        end
        bit_in(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0);
        chk("t4 clr on hit", int'(cnt2), 1);
        chk("t4 clr Z", int'(z2), 1);

        // Reset mid-fill and reset together with load
        do_reset();
        bit_in(1'b0);
        bit_in(1'b1);
        chk("t5 fill before rst", int'(fill0), 2);
        do_reset();
        chk("t5 rst Z", int'(z0), 0);
        chk("t5 rst fill", int'(fill0), 0);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("t5 no match", int'(z0), 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("t5 PAT_RST wins", int'(z0), 1);

        // N=1: pattern 1, Z follows X
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd1);
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom_range(0, 1));
            bit_in(b);
            chk("t6 N1 Z", int'(z3), int'(b));
        end

        // N=32: random pattern embedded in 100 random bits at 40..71
        do_reset();
        p32 = $urandom;
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, p32);
        for (int i = 0; i < 100; i++) begin
            if (i >= 40 && i < 72) b = p32[71 - i];
            else                   b = 1'($urandom_range(0, 1));
            bit_in(b);
            if (i == 71) chk("t6 N32 hit edge", int'(z4), 1);
        end
        chk("t6 N32 cnt", int'(cnt4), 1);

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 200) == 0, ($urandom % 40) == 0, ($urandom % 4) != 0,
                 1'($urandom_range(0, 1)), ($urandom % 50) == 0, $urandom);
        end

        repeat (2) idle();
        chk("scoreboard drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
